// File: rtl/opm_pkg.sv
// Shared definitions for the online power model (OPM) family:
// FSM state type, width helpers and default configuration.
package opm_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } opm_state_t;

    localparam int OPM_N_SIGS_DEF   = 5;
    localparam int OPM_SIG_W_DEF    = 4;
    localparam int OPM_W_B_DEF      = 6;
    localparam int OPM_WIN_LOG2_DEF = 4;

    function automatic int opm_clog2(input int v);
        return (v <= 1) ? 0 : $clog2(v);
    endfunction

    // Address widths must never collapse to zero bits.
    function automatic int opm_clog2_min1(input int v);
        return (opm_clog2(v) < 1) ? 1 : opm_clog2(v);
    endfunction

endpackage

// File: rtl/opm_tog_detect.sv
// Two-deep sample history of the monitored groups and the per-group toggle
// vector (OR of per-bit differences between the last two enabled samples).
module opm_tog_detect
    import opm_pkg::*;
#(
    parameter int N_SIGS = OPM_N_SIGS_DEF,
    parameter int SIG_W  = OPM_SIG_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      prime_i,
    input  logic [N_SIGS*SIG_W-1:0]   sigs_i,
    output logic [N_SIGS-1:0]         tog_o
);

    logic [N_SIGS*SIG_W-1:0] sigs_r_q;
    logic [N_SIGS*SIG_W-1:0] sigs_k_q;

    // The priming sample loads both stages so nothing toggles against reset zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sigs_r_q <= '0;
            sigs_k_q <= '0;
        end else if (en_i) begin
            sigs_r_q <= sigs_i;
            sigs_k_q <= prime_i ? sigs_i : sigs_r_q;
        end
    end

    always_comb begin
        tog_o = '0;
        for (int g = 0; g < N_SIGS; g++) begin
            tog_o[g] = |(sigs_r_q[g*SIG_W +: SIG_W] ^ sigs_k_q[g*SIG_W +: SIG_W]);
        end
    end

endmodule

// File: rtl/opm_window.sv
// Online power model: weighted toggle count per enabled sample, accumulated
// over a 2^WIN_LOG2-sample window into a total and a truncated average.
module opm_window
    import opm_pkg::*;
#(
    parameter int N_SIGS   = OPM_N_SIGS_DEF,
    parameter int SIG_W    = OPM_SIG_W_DEF,
    parameter int W_B      = OPM_W_B_DEF,
    parameter int WIN_LOG2 = OPM_WIN_LOG2_DEF,
    localparam int AW      = opm_clog2_min1(N_SIGS),
    localparam int SUM_W   = W_B + opm_clog2(N_SIGS + 1),
    localparam int WSUM_W  = SUM_W + WIN_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_SIGS*SIG_W-1:0]  sigs,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [W_B-1:0]           wr_data,
    input  logic                     win_clr,
    output logic [SUM_W-1:0]         cyc_pwr,
    output logic                     cyc_valid,
    output logic [WSUM_W-1:0]        win_sum,
    output logic [SUM_W-1:0]         win_avg,
    output logic                     win_valid
);

    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    opm_state_t              state_q;
    logic [N_SIGS-1:0]       tog;
    logic [W_B-1:0]          weight_q [N_SIGS];
    logic                    wr_ok;
    logic [SUM_W-1:0]        pwr_d;
    logic [SUM_W-1:0]        cyc_pwr_q;
    logic                    cyc_valid_q;
    logic [WSUM_W-1:0]       acc_q;
    logic [WSUM_W-1:0]       acc_tot;
    logic [WIN_LOG2-1:0]     cnt_q;
    logic [WSUM_W-1:0]       win_sum_q;
    logic [SUM_W-1:0]        win_avg_q;
    logic                    win_valid_q;

    opm_tog_detect #(
        .N_SIGS (N_SIGS),
        .SIG_W  (SIG_W)
    ) u_tog (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .prime_i (state_q == PRIME),
        .sigs_i  (sigs),
        .tog_o   (tog)
    );

    assign wr_ok = wr_en && (32'(wr_addr) < N_SIGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < N_SIGS; g++) begin
                weight_q[g] <= '0;
            end
        end else if (wr_ok) begin
            weight_q[wr_addr] <= wr_data;
        end
    end

    // Reads the pre-write weights, so a same-edge write lands one sample later.
    always_comb begin
        pwr_d = '0;
        for (int g = 0; g < N_SIGS; g++) begin
            if (tog[g]) begin
                pwr_d = pwr_d + SUM_W'(weight_q[g]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PRIME;
            cyc_pwr_q   <= '0;
            cyc_valid_q <= 1'b0;
        end else begin
            cyc_valid_q <= 1'b0;
            case (state_q)
                PRIME: begin
                    if (en) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        cyc_pwr_q   <= pwr_d;
                        cyc_valid_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign acc_tot = acc_q + WSUM_W'(cyc_pwr_q);

    // win_clr outranks both accumulation and completion of the current sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            win_sum_q   <= '0;
            win_avg_q   <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= 1'b0;
            if (win_clr) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (cyc_valid_q) begin
                if (cnt_q == CNT_LAST) begin
                    win_sum_q   <= acc_tot;
                    win_avg_q   <= SUM_W'(acc_tot >> WIN_LOG2);
                    win_valid_q <= 1'b1;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                end else begin
                    acc_q <= acc_tot;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // cyc_valid and win_valid are valid-only qualifiers (no ready): consumers
    // must take cyc_pwr / win_sum / win_avg in the cycle the qualifier is high.
    assign cyc_pwr   = cyc_pwr_q;
    assign cyc_valid = cyc_valid_q;
    assign win_sum   = win_sum_q;
    assign win_avg   = win_avg_q;
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_opm_window.sv
// Bench for opm_window: directed scenarios plus random traffic, every cycle
// compared against a queue-based behavioural model of the power window.
module tb_opm_window;

    localparam int N_SIGS   = 5;
    localparam int SIG_W    = 4;
    localparam int W_B      = 6;
    localparam int WIN_LOG2 = 2;
    localparam int AW       = 3;
    localparam int SUM_W    = 9;
    localparam int WSUM_W   = 11;
    localparam int WIN      = 1 << WIN_LOG2;
    localparam int SW       = N_SIGS * SIG_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [SW-1:0]     sigs;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W_B-1:0]    wr_data;
    logic              win_clr;
    logic [SUM_W-1:0]  cyc_pwr;
    logic              cyc_valid;
    logic [WSUM_W-1:0] win_sum;
    logic [SUM_W-1:0]  win_avg;
    logic              win_valid;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    opm_window #(
        .N_SIGS   (N_SIGS),
        .SIG_W    (SIG_W),
        .W_B      (W_B),
        .WIN_LOG2 (WIN_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sigs      (sigs),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .win_clr   (win_clr),
        .cyc_pwr   (cyc_pwr),
        .cyc_valid (cyc_valid),
        .win_sum   (win_sum),
        .win_avg   (win_avg),
        .win_valid (win_valid)
    );

    // ---------------- scoreboard / model ----------------
    int n_cmp = 0;
    int n_bad = 0;

    int            m_w [N_SIGS];
    logic [SW-1:0] samp_q [$];
    int            win_q [$];
    int            m_pwr, m_sum, m_avg;
    bit            m_cv, m_wv;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".cyc_valid"}, 32'(cyc_valid), 32'(m_cv));
        check_val({tag, ".cyc_pwr"},   32'(cyc_pwr),   32'(m_pwr));
        check_val({tag, ".win_valid"}, 32'(win_valid), 32'(m_wv));
        check_val({tag, ".win_sum"},   32'(win_sum),   32'(m_sum));
        check_val({tag, ".win_avg"},   32'(win_avg),   32'(m_avg));
    endtask

    task automatic model_clear();
        for (int g = 0; g < N_SIGS; g++) m_w[g] = 0;
        samp_q.delete();
        win_q.delete();
        m_pwr = 0; m_sum = 0; m_avg = 0; m_cv = 0; m_wv = 0;
    endtask

    // Weighted count of groups that differ between two samples.
    function automatic int model_pwr(input logic [SW-1:0] a, input logic [SW-1:0] b);
        int            p;
        logic [SW-1:0] d;
        p = 0;
        for (int g = 0; g < N_SIGS; g++) begin
            d = (a ^ b) >> (g * SIG_W);
            if (d[SIG_W-1:0] != '0) p += m_w[g];
        end
        return p;
    endfunction

    // ---------------- driver ----------------
    // Predict the effect of the coming edge from the current inputs, take the
    // edge, then compare all outputs.
    task automatic step(input string tag);
        int nx_pwr, nx_sum, nx_avg, s;
        bit nx_cv, nx_wv;
        int n;
        n      = samp_q.size();
        nx_pwr = m_pwr; nx_sum = m_sum; nx_avg = m_avg;
        nx_cv  = 0;     nx_wv  = 0;
        if (en && n >= 1) begin
            nx_cv  = 1;
            nx_pwr = (n >= 2) ? model_pwr(samp_q[n-1], samp_q[n-2]) : 0;
        end
        if (win_clr) begin
            win_q.delete();
        end else if (m_cv) begin
            win_q.push_back(m_pwr);
            if (win_q.size() == WIN) begin
                s = 0;
                foreach (win_q[i]) s += win_q[i];
                nx_sum = s;
                nx_avg = s >> WIN_LOG2;
                nx_wv  = 1;
                win_q.delete();
            end
        end
        if (en) begin
            samp_q.push_back(sigs);
            if (samp_q.size() > 2) void'(samp_q.pop_front());
        end
        if (wr_en && int'(wr_addr) < N_SIGS) m_w[wr_addr] = int'(wr_data);
        @(posedge clk);
        #1;
        m_pwr = nx_pwr; m_sum = nx_sum; m_avg = nx_avg; m_cv = nx_cv; m_wv = nx_wv;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; win_clr = 1'b0;
        sigs = '0; wr_addr = '0; wr_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("reset");
    endtask

    task automatic write_weights();
        int wv [N_SIGS] = '{23, 25, 24, 11, 45};
        en = 1'b0;
        for (int g = 0; g < N_SIGS; g++) begin
            wr_en = 1'b1; wr_addr = AW'(g); wr_data = W_B'(wv[g]);
            step("wr");
        end
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 6'd63;
        step("wr_oob");
        wr_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses, hits;

        do_reset();
        write_weights();

        // Prime: no valid on the first sample, valid with zero power next.
        en = 1'b1; sigs = 20'h12345;
        step("prime0");
        check_val("prime_first_edge_valid", 32'(cyc_valid), 0);
        step("prime1");
        check_val("prime_valid", 32'(cyc_valid), 1);
        check_val("prime_pwr", 32'(cyc_pwr), 0);

        // Single group toggle on bit 13 (group 3), then back.
        hits = 0;
        sigs = sigs ^ (20'h1 << 13);
        step("tog1");
        if (cyc_pwr == 11) hits++;
        sigs = sigs ^ (20'h1 << 13);
        for (int i = 0; i < 4; i++) begin
            step("tog1");
            if (cyc_valid && cyc_pwr == 11) hits++;
        end
        check_val("single_toggle_hits", 32'(hits), 2);

        // All groups toggle every cycle.
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            sigs = ~sigs;
            step("full");
            if (win_valid) pulses++;
        end
        check_val("full_pulses", 32'(pulses), 4);
        check_val("full_win_sum", 32'(win_sum), 512);
        check_val("full_win_avg", 32'(win_avg), 128);

        // Weight write racing a computation.
        sigs = ~sigs; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 6'd63;
        step("wrace");
        check_val("race_old_weight", 32'(cyc_pwr), 128);
        sigs = ~sigs; wr_addr = 3'd7; wr_data = 6'd0;
        step("wrace");
        check_val("race_new_weight", 32'(cyc_pwr), 146);
        sigs = ~sigs; wr_en = 1'b0;
        step("wrace");
        check_val("race_oob_ignored", 32'(cyc_pwr), 146);

        // Enable gap mid-window.
        for (int i = 0; i < 2; i++) begin sigs = ~sigs; step("gap"); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin sigs = ~sigs; step("gap"); end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin sigs = ~sigs; step("gap"); end

        // Window abort.
        win_clr = 1'b1; sigs = ~sigs;
        step("clr");
        win_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin sigs = ~sigs; step("clr"); end

        // Asynchronous reset between edges.
        for (int i = 0; i < 2; i++) begin sigs = ~sigs; step("pre_arst"); end
        rst = 1'b1;
        #2;
        check_val("arst_cyc_valid", 32'(cyc_valid), 0);
        check_val("arst_cyc_pwr",   32'(cyc_pwr),   0);
        check_val("arst_win_valid", 32'(win_valid), 0);
        check_val("arst_win_sum",   32'(win_sum),   0);
        check_val("arst_win_avg",   32'(win_avg),   0);
        model_clear();
        en = 1'b0; wr_en = 1'b0; win_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        write_weights();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin sigs = ~sigs; step("post_arst"); end
        check_val("post_arst_sum_held", 32'(win_sum), 0);
        sigs = ~sigs;
        step("post_arst");
        check_val("post_arst_win_valid", 32'(win_valid), 1);
        check_val("post_arst_win_sum", 32'(win_sum), 384);
        check_val("post_arst_win_avg", 32'(win_avg), 96);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 9) < 8);
            win_clr = ($urandom_range(0, 24) == 0);
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = W_B'($urandom);
            case ($urandom_range(0, 2))
                0: sigs = SW'($urandom);
                1: sigs = sigs ^ (SW'(1) << $urandom_range(0, SW - 1));
                default: ;
            endcase
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
